// File: rtl/muldiv_types.sv
// -----------------------------------------------------------------------------
// muldiv_types
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
//   m_funct3_t     : M-extension operation encoding (funct3 field)
//   muldiv_state_t : sequencer FSM states
//   M_FUNCT7       : funct7 value that selects the M extension (the decoder
//                    filters on it; the sequencer itself never checks it)
// Helper functions report per-operand signedness for each operation.
// Optional feature macro used by the datapath: MULDIV_EARLY_OUT_EN.
// -----------------------------------------------------------------------------
package muldiv_types;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } m_funct3_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } muldiv_state_t;

    localparam logic [6:0] M_FUNCT7 = 7'b0000001;

    // Operand A is treated as signed for mulh, mulhsu, div and rem.
    function automatic logic op_signed_a(input m_funct3_t op);
        return (op == F3_MULH) || (op == F3_MULHSU) ||
               (op == F3_DIV)  || (op == F3_REM);
    endfunction

    // Operand B is treated as signed for mulh, div and rem.
    function automatic logic op_signed_b(input m_funct3_t op);
        return (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
    endfunction

    // funct3[2] separates the divide family from the multiply family.
    function automatic logic op_is_div(input m_funct3_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// -----------------------------------------------------------------------------
// muldiv_datapath
// Arithmetic half of the multiply/divide sequencer, steered by the controller.
// Holds the 2*WIDTH accumulator (product, or {remainder, quotient} during a
// divide), the operand magnitudes, the result sign flags and the result
// register.
//   clk, rst      : clock, asynchronous active-low reset
//   prep          : compute magnitudes/signs from op, a, b and seed accumulator
//   step          : one shift-add (multiply) or restoring (divide) iteration
//   fix           : apply sign correction and latch the selected result
//   special       : latch the divide special-case result (B=0 or overflow)
//   op, a, b      : captured operation and raw operands
//   count         : current iteration index (used by the early-out path)
//   early_out     : multiply has no remaining multiplier bits to process
//   result        : registered rd value
// Optional macro MULDIV_EARLY_OUT_EN: when defined, a multiply whose remaining
// multiplier bits are all zero finishes the remaining shifts in one step.
// -----------------------------------------------------------------------------
module muldiv_datapath
    import muldiv_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prep,
    input  logic                       step,
    input  logic                       fix,
    input  logic                       special,
    input  m_funct3_t                  op,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [$clog2(WIDTH)-1:0]   count,
    output logic                       early_out,
    output logic [WIDTH-1:0]           result
);

    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0]   amag_q,   amag_d;
    logic [WIDTH-1:0]   bmag_q,   bmag_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   amag, bmag;
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] mul_jump;
    logic               early_hit;
    logic [WIDTH:0]     div_rp, div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fix_sel, special_sel;

    always_comb begin
        sign_a = op_signed_a(op) && a[WIDTH-1];
        sign_b = op_signed_b(op) && b[WIDTH-1];
        amag   = sign_a ? -a : a;
        bmag   = sign_b ? -b : b;

        acc_hi = acc_q[2*WIDTH-1:WIDTH];
        acc_lo = acc_q[WIDTH-1:0];

        // Shift-add: multiplier lives in the low half and drains out the
        // bottom while product bits fill in from the top.
        mul_sum  = {1'b0, acc_hi} + (acc_q[0] ? {1'b0, amag_q} : '0);
        mul_next = {mul_sum, acc_lo[WIDTH-1:1]};

        // Restoring divide: {remainder, dividend} shifts left one bit, the
        // divisor is trial-subtracted, and the borrow decides the quotient bit.
        div_rp   = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_rp - {1'b0, bmag_q};
        div_next = div_diff[WIDTH] ? {div_rp[WIDTH-1:0],   acc_lo[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};

        prod = neg_lo_q ? -acc_q  : acc_q;
        quo  = neg_lo_q ? -acc_lo : acc_lo;
        rem  = neg_hi_q ? -acc_hi : acc_hi;

        case (op)
            F3_MUL:                         fix_sel = prod[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:   fix_sel = prod[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU:                fix_sel = quo;
            default:                        fix_sel = rem;
        endcase

        // Divide by zero: quotient all ones, remainder = dividend.
        // Signed overflow: quotient = dividend, remainder = 0.
        if ((op == F3_DIV) || (op == F3_DIVU)) begin
            special_sel = (b == '0) ? '1 : a;
        end else begin
            special_sel = (b == '0) ? a : '0;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [$clog2(WIDTH):0] remain;

    always_comb begin
        remain    = ($clog2(WIDTH)+1)'(WIDTH) - {1'b0, count};
        // Bits above the current multiplier LSB are exhausted: this step's
        // add still happens, then every remaining shift is taken at once.
        early_hit = !op_is_div(op) && (((bmag_q >> count) >> 1) == '0);
        mul_jump  = (2*WIDTH)'({mul_sum, acc_lo} >> remain);
    end
`else
    logic unused_count;

    always_comb begin
        early_hit    = 1'b0;
        mul_jump     = mul_next;
        unused_count = ^count;
    end
`endif

    assign early_out = early_hit;

    always_comb begin
        acc_d    = acc_q;
        amag_d   = amag_q;
        bmag_d   = bmag_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        result_d = result_q;

        if (prep) begin
            acc_d    = op_is_div(op) ? {{WIDTH{1'b0}}, amag} : {{WIDTH{1'b0}}, bmag};
            amag_d   = amag;
            bmag_d   = bmag;
            neg_lo_d = sign_a ^ sign_b;
            neg_hi_d = sign_a;
        end
        if (step) begin
            if (op_is_div(op)) begin
                acc_d = div_next;
            end else begin
                acc_d = early_hit ? mul_jump : mul_next;
            end
        end
        if (fix) begin
            result_d = fix_sel;
        end
        if (special) begin
            result_d = special_sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            amag_q   <= '0;
            bmag_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            amag_q   <= amag_d;
            bmag_q   <= bmag_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/muldiv_controller.sv
// -----------------------------------------------------------------------------
// muldiv_controller
// Iterative RV32M multiply/divide sequencer placed beside the execute ALU.
// Captures one M op, walks IDLE -> PREP -> CALC -> FIX -> DONE, and stalls
// execute (busy) until the single-cycle done pulse. Divide special cases skip
// CALC; flush aborts any in-flight op without a done pulse.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   start     : request, only sampled in IDLE
//   funct3    : M operation (mul..remu)
//   rs1_data  : operand A (multiplicand / dividend)
//   rs2_data  : operand B (multiplier / divisor)
//   flush     : abort the current op
//   busy      : op in flight (PREP, CALC, FIX)
//   done      : one-cycle result-valid pulse
//   result    : rd write value, held until overwritten by a later op
// Optional macro MULDIV_EARLY_OUT_EN (implemented in muldiv_datapath): early
// multiply termination once the remaining multiplier bits are zero.
// -----------------------------------------------------------------------------
module muldiv_controller
    import muldiv_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_t    state_q, state_d;
    m_funct3_t        op_q,    op_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic prep, step, fix, special;
    logic special_case;
    logic early_out;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        special_case = op_is_div(op_q) &&
                       ((b_q == '0) ||
                        (((op_q == F3_DIV) || (op_q == F3_REM)) &&
                         (a_q == MIN_NEG) && (b_q == '1)));
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        prep    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        special = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d    = m_funct3_t'(funct3);
                    a_d     = rs1_data;
                    b_d     = rs2_data;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                prep  = 1'b1;
                cnt_d = '0;
                if (special_case) begin
                    special = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                step = 1'b1;
                if (early_out || (cnt_q == CNT_W'(WIDTH-1))) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIX: begin
                fix     = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over every in-state transition and suppresses all
        // datapath strobes, so the previous result survives an abort.
        if (flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            prep    = 1'b0;
            step    = 1'b0;
            fix     = 1'b0;
            special = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= F3_MUL;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done = (state_q == S_DONE);

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .prep      (prep),
        .step      (step),
        .fix       (fix),
        .special   (special),
        .op        (op_q),
        .a         (a_q),
        .b         (b_q),
        .count     (cnt_q),
        .early_out (early_out),
        .result    (result)
    );

endmodule

// File: tb/tb_muldiv_controller.sv
// -----------------------------------------------------------------------------
// tb_muldiv_controller
// Directed and randomized checks of muldiv_controller (WIDTH=32) against a
// reference model built from 64-bit integer arithmetic and the RISC-V divide
// rules. Latency expectations follow MULDIV_EARLY_OUT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_muldiv_controller;

    localparam int WIDTH = 32;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        start    = 1'b0;
    logic        flush    = 1'b0;
    logic [2:0]  funct3   = 3'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_controller #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic is_overflow(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return ((f == 3'd4) || (f == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, ua, ub;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f)
            3'd0: begin p = 64'(ua * ub); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0)                 return 32'hFFFF_FFFF;
                if (is_overflow(f, a, b))   return a;
                return 32'(int'(a) / int'(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0)                 return a;
                if (is_overflow(f, a, b))   return 32'h0;
                return 32'(int'(a) % int'(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from the start edge to the done cycle.
    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bm;
        int          msb;
        if (f[2] && ((b == 0) || is_overflow(f, a, b))) return 2;
        bm  = b;
        msb = 0;
`ifdef MULDIV_EARLY_OUT_EN
        if (!f[2]) begin
            if ((f == 3'd1) && b[31]) bm = -b;
            for (int i = 0; i < 32; i++) if (bm[i]) msb = i;
            return msb + 4;
        end
`endif
        return WIDTH + 3 + msb - msb + int'(bm == bm) - 1;
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit noise);
        logic [31:0] exp_res;
        int          exp_lat;
        int          cyc;
        bit          busy_ok;
        exp_res = ref_result(f, a, b);
        exp_lat = ref_latency(f, a, b);
        @(negedge clk);
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (noise && cyc == 5) begin
                start    = 1'b1;
                funct3   = 3'($urandom);
                rs1_data = $urandom;
                rs2_data = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        $display("op f3=%0d a=0x%08h b=0x%08h noise=%0d result=0x%08h exp=0x%08h lat=%0d exp_lat=%0d",
                 f, a, b, noise, result, exp_res, cyc, exp_lat);
        check_bit ("done_seen",   done,    1'b1);
        check_bit ("busy_during", busy_ok, 1'b1);
        check_int ("latency",     cyc,     exp_lat);
        check_word("result",      result,  exp_res);
        check_bit ("busy_at_done", busy,   1'b0);
        @(posedge clk); #1;
        check_bit ("done_one_cycle", done, 1'b0);
        check_bit ("idle_after",     busy, 1'b0);
        check_word("result_held",    result, exp_res);
    endtask

    initial begin
        logic [31:0] prev;
        int          cyc;
        bit          saw_done;
        logic [31:0] ra, rb;
        logic [2:0]  rf;

        // Reset state
        #12;
        check_bit ("rst_busy",   busy,   1'b0);
        check_bit ("rst_done",   done,   1'b0);
        check_word("rst_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed plan
        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 1'b0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         1'b0);
        run_op(3'd5, 32'd100,       32'd7,         1'b0);
        run_op(3'd7, 32'd100,       32'd7,         1'b1);
        run_op(3'd5, 32'd5,         32'd0,         1'b0);
        run_op(3'd7, 32'd5,         32'd0,         1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd0, 32'h1234,      32'd1,         1'b0);
        run_op(3'd0, 32'hABCD_0123, 32'h8765_4321, 1'b1);

        // Flush during CALC iteration 10
        prev = result;
        @(negedge clk);
        funct3   = 3'd3;
        rs1_data = $urandom;
        rs2_data = $urandom | 32'h8000_0000;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        cyc      = 1;
        saw_done = 1'b0;
        while (cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
            if (done) saw_done = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        $display("flush at cycle %0d busy=%b done=%b result=0x%08h", cyc, busy, done, result);
        check_bit ("flush_no_early_done", saw_done, 1'b0);
        check_bit ("flush_busy",   busy,   1'b0);
        check_bit ("flush_done",   done,   1'b0);
        check_word("flush_result", result, prev);
        run_op(3'd0, 32'd3, 32'd4, 1'b0);

        // flush together with start in IDLE: start ignored
        prev = result;
        @(negedge clk);
        funct3   = 3'd0;
        rs1_data = 32'd9;
        rs2_data = 32'd9;
        start    = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        $display("start+flush in idle busy=%b result=0x%08h", busy, result);
        check_bit ("start_flush_busy", busy, 1'b0);
        @(posedge clk); #1;
        check_bit ("start_flush_done", done, 1'b0);
        check_word("start_flush_result", result, prev);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        funct3   = 3'd3;
        rs1_data = 32'h1357_9BDF;
        rs2_data = 32'hF000_0001;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        $display("async reset mid-op busy=%b done=%b result=0x%08h", busy, done, result);
        check_bit ("arst_busy",   busy,   1'b0);
        check_bit ("arst_done",   done,   1'b0);
        check_word("arst_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_bit("arst_no_done", done, 1'b0);
        end

        // Randomized ops with boundary operands mixed in
        for (int n = 0; n < 30; n++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = -32'($urandom_range(1, 1000));
                default: ;
            endcase
            run_op(rf, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
